// File: rtl/reg_40xx_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_40xx_wr_arbiter_if
// Purpose : Bundles the three-producer write request channel and the two
//           register-file write ports driven by reg_40xx_wr_arbiter.
// Signals :
//   req_valid     [2:0]          per-producer request valid (bit i = producer i)
//   req_addr      [17:0]         producer i address at [6i+5:6i]
//   req_data      [3*WIDTH-1:0]  producer i data at [WIDTH*(i+1)-1:WIDTH*i]
//   req_ready     [2:0]          combinational grant, transfer on valid&ready
//   wr0_en/addr/data             register file write port 0 (registered)
//   wr1_en/addr/data             register file write port 1 (registered)
//   bad_addr                     sticky flag: an address >= 40 was accepted
//   collision_cnt [CNT_WIDTH-1:0] saturating count of same-address stall cycles
// Modports: master = producer/register-file side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface reg_40xx_wr_arbiter_if #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 8
);
  logic [2:0]           req_valid;
  logic [17:0]          req_addr;
  logic [3*WIDTH-1:0]   req_data;
  logic [2:0]           req_ready;
  logic                 wr0_en;
  logic [5:0]           wr0_addr;
  logic [WIDTH-1:0]     wr0_data;
  logic                 wr1_en;
  logic [5:0]           wr1_addr;
  logic [WIDTH-1:0]     wr1_data;
  logic                 bad_addr;
  logic [CNT_WIDTH-1:0] collision_cnt;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data, bad_addr, collision_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data, bad_addr, collision_cnt
  );
endinterface

// File: rtl/reg_40xx_wr_arbiter.sv
// ---------------------------------------------------------------------------
// reg_40xx_wr_arbiter
// Purpose : Write-port arbiter for the 40-entry, 1-read/2-write register
//           file. Up to two of three producers are granted per cycle in
//           round-robin order; the two grants never target the same address,
//           so the file never sees a colliding write. Grants are registered
//           onto the wr0/wr1 ports one cycle later.
// Ports   :
//   i_clk  clock, all state updates on the rising edge
//   i_rst  synchronous active-low reset (asserted when 0)
//   bus    reg_40xx_wr_arbiter_if.slave, request channel + write ports
// ---------------------------------------------------------------------------
module reg_40xx_wr_arbiter #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 8
) (
  input logic                   i_clk,
  input logic                   i_rst,
  reg_40xx_wr_arbiter_if.slave  bus
);

  localparam logic [5:0] NUM_ENTRIES = 6'd40;

  logic [1:0]           r_rrPtr;
  logic                 r_wr0En;
  logic [5:0]           r_wr0Addr;
  logic [WIDTH-1:0]     r_wr0Data;
  logic                 r_wr1En;
  logic [5:0]           r_wr1Addr;
  logic [WIDTH-1:0]     r_wr1Data;
  logic                 r_badAddr;
  logic [CNT_WIDTH-1:0] r_collisionCnt;

  logic                 w_aFound;
  logic                 w_bFound;
  logic                 w_addrStall;
  logic [1:0]           w_aIdx;
  logic [1:0]           w_bIdx;
  logic [5:0]           w_aAddr;
  logic [5:0]           w_bAddr;
  logic [WIDTH-1:0]     w_aData;
  logic [WIDTH-1:0]     w_bData;
  logic [1:0]           w_idx;
  logic [5:0]           w_addr;
  logic [2:0]           w_ready;
  logic                 w_aIssue;
  logic                 w_bIssue;
  logic                 w_badSeen;

  // Producer visited at position 'step' of the scan starting at 'ptr'.
  function automatic logic [1:0] scanIdx(input logic [1:0] ptr, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, ptr} + {1'b0, step};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  function automatic logic [1:0] nextPtr(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Scan producers in round-robin order. The first valid one takes slot A.
  // Later producers with slot A's address are skipped (a same-address stall);
  // the first one with a different address takes slot B and ends the search.
  // Out-of-range addresses still take part, so a bad slot A can stall others.
  always_comb begin
    w_aFound    = 1'b0;
    w_bFound    = 1'b0;
    w_addrStall = 1'b0;
    w_aIdx      = 2'd0;
    w_bIdx      = 2'd0;
    w_aAddr     = 6'd0;
    w_bAddr     = 6'd0;
    w_aData     = '0;
    w_bData     = '0;
    w_idx       = 2'd0;
    w_addr      = 6'd0;
    for (int k = 0; k < 3; k++) begin
      w_idx  = scanIdx(r_rrPtr, 2'(k));
      w_addr = bus.req_addr[6*w_idx +: 6];
      if (bus.req_valid[w_idx]) begin
        if (!w_aFound) begin
          w_aFound = 1'b1;
          w_aIdx   = w_idx;
          w_aAddr  = w_addr;
          w_aData  = bus.req_data[WIDTH*w_idx +: WIDTH];
        end else if (!w_bFound) begin
          if (w_addr == w_aAddr) begin
            w_addrStall = 1'b1;
          end else begin
            w_bFound = 1'b1;
            w_bIdx   = w_idx;
            w_bAddr  = w_addr;
            w_bData  = bus.req_data[WIDTH*w_idx +: WIDTH];
          end
        end
      end
    end
  end

  // Ready is withheld entirely while reset is asserted.
  always_comb begin
    w_ready = 3'b000;
    if (i_rst) begin
      if (w_aFound) w_ready[w_aIdx] = 1'b1;
      if (w_bFound) w_ready[w_bIdx] = 1'b1;
    end
  end

  assign w_aIssue  = w_aFound && (w_aAddr < NUM_ENTRIES);
  assign w_bIssue  = w_bFound && (w_bAddr < NUM_ENTRIES);
  assign w_badSeen = (w_aFound && !w_aIssue) || (w_bFound && !w_bIssue);

  // Issue stage: reset wins over any grant made in the same cycle. A bad
  // address is consumed (ready was given) but its port enable stays low and
  // the port's address/data keep their last issued values.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rrPtr        <= 2'd0;
      r_wr0En        <= 1'b0;
      r_wr0Addr      <= 6'd0;
      r_wr0Data      <= '0;
      r_wr1En        <= 1'b0;
      r_wr1Addr      <= 6'd0;
      r_wr1Data      <= '0;
      r_badAddr      <= 1'b0;
      r_collisionCnt <= '0;
    end else begin
      r_wr0En <= w_aIssue;
      if (w_aIssue) begin
        r_wr0Addr <= w_aAddr;
        r_wr0Data <= w_aData;
      end
      r_wr1En <= w_bIssue;
      if (w_bIssue) begin
        r_wr1Addr <= w_bAddr;
        r_wr1Data <= w_bData;
      end
      if (w_badSeen) r_badAddr <= 1'b1;
      if (w_aFound) r_rrPtr <= w_bFound ? nextPtr(w_bIdx) : nextPtr(w_aIdx);
      if (w_addrStall && (r_collisionCnt != {CNT_WIDTH{1'b1}}))
        r_collisionCnt <= r_collisionCnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.wr0_en        = r_wr0En;
  assign bus.wr0_addr      = r_wr0Addr;
  assign bus.wr0_data      = r_wr0Data;
  assign bus.wr1_en        = r_wr1En;
  assign bus.wr1_addr      = r_wr1Addr;
  assign bus.wr1_data      = r_wr1Data;
  assign bus.bad_addr      = r_badAddr;
  assign bus.collision_cnt = r_collisionCnt;

endmodule
